// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM command-port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} arb_state_e;
    typedef enum logic [1:0] {G_P0R, G_P1R, G_P1W} grant_e;

    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 16;
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    // Bit positions of the one-hot grant vector produced by the picker
    localparam int PICK_P0R = 0;
    localparam int PICK_P1R = 1;
    localparam int PICK_P1W = 2;

    function automatic grant_e pick_to_grant(input logic [2:0] pick);
        grant_e g;
        g = G_P0R;
        if (pick[PICK_P1R])      g = G_P1R;
        else if (pick[PICK_P1W]) g = G_P1W;
        return g;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational priority picker: P0R > P1R > P1W, with port 1 forced once
// the port-0 burst budget is used up.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic       p0_rd,
    input  logic       p1_rd,
    input  logic       p1_wr,
    input  logic       burst_sat,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        if (burst_sat && (p1_rd || p1_wr)) begin
            if (p1_rd) grant[PICK_P1R] = 1'b1;
            else       grant[PICK_P1W] = 1'b1;
        end else if (p0_rd) begin
            grant[PICK_P0R] = 1'b1;
        end else if (p1_rd) begin
            grant[PICK_P1R] = 1'b1;
        end else if (p1_wr) begin
            grant[PICK_P1W] = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the SDRAM controller command port: serialises
// display reads and draw-engine reads/writes, with a hung-controller timeout.
//
// state | meaning
// IDLE  | sample requests, grant one and load the mem_* payload
// BUSY  | mem_req held, waiting for mem_done or timeout
// ACK   | one-cycle done pulse to the granted requester
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = SDRAM_ADDR_W,
    parameter int DATA_W       = SDRAM_DATA_W,
    parameter int P0_BURST_MAX = 8,
    parameter int TIMEOUT_CYC  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_rd_req,
    input  logic [ADDR_W-1:0] p0_rd_addr,
    output logic              p0_rd_done,
    output logic [DATA_W-1:0] p0_rd_data,
    input  logic              p1_rd_req,
    input  logic              p1_wr_req,
    input  logic [ADDR_W-1:0] p1_rd_addr,
    input  logic [ADDR_W-1:0] p1_wr_addr,
    input  logic [DATA_W-1:0] p1_wr_data,
    output logic              p1_rd_done,
    output logic              p1_wr_done,
    output logic [DATA_W-1:0] p1_rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              timeout_err
);

    localparam int BURST_W = $clog2(P0_BURST_MAX + 1);
    localparam int WAIT_W  = $clog2(TIMEOUT_CYC + 1);

    arb_state_e        state;
    grant_e            grant_id;
    logic [BURST_W-1:0] burst_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [2:0]        pick;
    logic              p1_pend;
    logic              burst_sat;
    logic              wait_tc;
    logic [DATA_W-1:0] ret_data;

    assign p1_pend   = p1_rd_req || p1_wr_req;
    assign burst_sat = (burst_cnt == BURST_W'(P0_BURST_MAX));
    assign wait_tc   = (wait_cnt == WAIT_W'(TIMEOUT_CYC));
    // A completion in the timeout cycle wins over the abort
    assign ret_data  = mem_done ? mem_rdata : DATA_W'(TIMEOUT_DATA);

    sdram_arb_pick u_pick (
        .p0_rd     (p0_rd_req),
        .p1_rd     (p1_rd_req),
        .p1_wr     (p1_wr_req),
        .burst_sat (burst_sat),
        .grant     (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_id    <= G_P0R;
            burst_cnt   <= '0;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            p0_rd_done  <= 1'b0;
            p1_rd_done  <= 1'b0;
            p1_wr_done  <= 1'b0;
            p0_rd_data  <= '0;
            p1_rd_data  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!p1_pend) burst_cnt <= '0;
            case (state)
                IDLE: begin
                    if (|pick) begin
                        grant_id <= pick_to_grant(pick);
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= BUSY;
                        if (pick[PICK_P0R]) begin
                            mem_we   <= 1'b0;
                            mem_addr <= p0_rd_addr;
                            if (p1_pend && !burst_sat) burst_cnt <= burst_cnt + 1'b1;
                        end else if (pick[PICK_P1R]) begin
                            mem_we    <= 1'b0;
                            mem_addr  <= p1_rd_addr;
                            burst_cnt <= '0;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= p1_wr_addr;
                            mem_wdata <= p1_wr_data;
                            burst_cnt <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_done || wait_tc) begin
                        mem_req <= 1'b0;
                        state   <= ACK;
                        if (!mem_done) timeout_err <= 1'b1;
                        case (grant_id)
                            G_P0R: begin
                                p0_rd_done <= 1'b1;
                                p0_rd_data <= ret_data;
                            end
                            G_P1R: begin
                                p1_rd_done <= 1'b1;
                                p1_rd_data <= ret_data;
                            end
                            default: p1_wr_done <= 1'b1;
                        endcase
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ACK: begin
                    p0_rd_done <= 1'b0;
                    p1_rd_done <= 1'b0;
                    p1_wr_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a scoreboard of expected accesses is
// filled when requests are raised and drained as the controller model serves them.
module tb_sdram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_rd_req, p1_rd_req, p1_wr_req;
    logic [AW-1:0] p0_rd_addr, p1_rd_addr, p1_wr_addr;
    logic [DW-1:0] p1_wr_data;
    logic          p0_rd_done, p1_rd_done, p1_wr_done;
    logic [DW-1:0] p0_rd_data, p1_rd_data;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          timeout_err;

    sdram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .P0_BURST_MAX(8), .TIMEOUT_CYC(15)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_rd_req(p0_rd_req), .p0_rd_addr(p0_rd_addr),
        .p0_rd_done(p0_rd_done), .p0_rd_data(p0_rd_data),
        .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req),
        .p1_rd_addr(p1_rd_addr), .p1_wr_addr(p1_wr_addr), .p1_wr_data(p1_wr_data),
        .p1_rd_done(p1_rd_done), .p1_wr_done(p1_wr_done), .p1_rd_data(p1_rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;   // 0 = P0R, 1 = P1R, 2 = P1W
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   req_cyc;
    int   done_cyc;
    bit   keep_p0 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int port, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        txn_t t;
        t.port = port; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        sb.push_back(t);
    endtask

    // Controller model: serve the next expected access with mem_done lat cycles after mem_req
    task automatic service(input string tag, input int lat);
        txn_t t;
        int   n;
        logic [2:0] exp_done;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        t = sb.pop_front();
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_mem_req"}, mem_req, 1'b1);
        chk({tag, "_mem_we"}, mem_we, (t.port == 2));
        chk({tag, "_mem_addr"}, mem_addr, t.addr);
        if (t.port == 2) chk({tag, "_mem_wdata"}, mem_wdata, t.wdata);
        repeat (lat) tick();
        chk({tag, "_req_held"}, mem_req, 1'b1);
        mem_done  = 1'b1;
        mem_rdata = t.rdata;
        tick();
        mem_done  = 1'b0;
        mem_rdata = DW'($urandom);
        done_cyc  = cyc;
        exp_done  = 3'b001 << t.port;
        chk({tag, "_done"}, {p1_wr_done, p1_rd_done, p0_rd_done}, exp_done);
        chk({tag, "_req_drop"}, mem_req, 1'b0);
        if (t.port == 0) chk({tag, "_p0_data"}, p0_rd_data, t.rdata);
        if (t.port == 1) chk({tag, "_p1_data"}, p1_rd_data, t.rdata);
        if (t.port == 0 && !keep_p0) p0_rd_req = 1'b0;
        if (t.port == 1) p1_rd_req = 1'b0;
        if (t.port == 2) p1_wr_req = 1'b0;
        tick();
        chk({tag, "_done_1cyc"}, {p1_wr_done, p1_rd_done, p0_rd_done}, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int busy;
        rst = 1'b1;
        p0_rd_req = 0; p1_rd_req = 0; p1_wr_req = 0;
        p0_rd_addr = '0; p1_rd_addr = '0; p1_wr_addr = '0; p1_wr_data = '0;
        mem_done = 0; mem_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_ctrl", {mem_req, mem_we, p0_rd_done, p1_rd_done, p1_wr_done, timeout_err}, 6'd0);
        chk("rst_mem_addr", mem_addr, 24'd0);
        chk("rst_mem_wdata", mem_wdata, 16'd0);
        chk("rst_rd_data", {p0_rd_data, p1_rd_data}, 32'd0);

        // Stray mem_done in IDLE is ignored
        mem_done = 1'b1; tick(); mem_done = 1'b0; tick();
        chk("stray_done", {mem_req, p1_wr_done, p1_rd_done, p0_rd_done}, 4'd0);

        // Single P0 read, 4-cycle controller latency
        p0_rd_addr = 24'h0A0B0C;
        p0_rd_req  = 1'b1;
        req_cyc    = cyc;
        push(0, 24'h0A0B0C, 16'h0, 16'h1234);
        service("p0_single", 4);
        chk("p0_latency", done_cyc - req_cyc, 6);

        // P1 write
        p1_wr_addr = 24'd384599;
        p1_wr_data = 16'h0042;
        p1_wr_req  = 1'b1;
        push(2, 24'd384599, 16'h0042, 16'h5555);
        service("p1_wr", 1);

        // mem_done in the same cycle the timeout would fire counts as success
        p1_rd_addr = 24'h123456;
        p1_rd_req  = 1'b1;
        push(1, 24'h123456, 16'h0, 16'hBEEF);
        service("tc_edge", 15);
        chk("tc_edge_no_err", timeout_err, 1'b0);

        // Burst budget: 8 P0 grants, then P1 read, then P0 again
        keep_p0    = 1'b1;
        p0_rd_addr = 24'h000100;
        p1_rd_addr = 24'h3F0000;
        p0_rd_req  = 1'b1;
        p1_rd_req  = 1'b1;
        for (int i = 0; i < 8; i++) push(0, 24'h000100, 16'h0, 16'h1000 + 16'(i));
        push(1, 24'h3F0000, 16'h0, 16'h2222);
        push(0, 24'h000100, 16'h0, 16'h3333);
        for (int i = 0; i < 9; i++) service("burst", 1 + (i % 3));
        keep_p0 = 1'b0;
        service("burst_resume", 2);

        // Simultaneous P1 read and write: read first, write kept pending
        p1_rd_addr = 24'h00ABCD;
        p1_wr_addr = 24'h00DCBA;
        p1_wr_data = 16'h7E57;
        p1_rd_req  = 1'b1;
        p1_wr_req  = 1'b1;
        push(1, 24'h00ABCD, 16'h0, 16'h4321);
        push(2, 24'h00DCBA, 16'h7E57, 16'h9999);
        service("dual_rd", 2);
        service("dual_wr", 3);
        chk("p1_data_hold", p1_rd_data, 16'h4321);

        // Controller never answers: abort after 16 BUSY cycles
        p0_rd_addr = 24'h055555;
        p0_rd_req  = 1'b1;
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin tick(); n++; end
        busy = 0;
        while (mem_req === 1'b1 && busy < 100) begin tick(); busy++; end
        chk("to_busy_cycles", busy, 16);
        chk("to_done", {p1_wr_done, p1_rd_done, p0_rd_done}, 3'b001);
        chk("to_data", p0_rd_data, 16'hDEAD);
        chk("to_err", timeout_err, 1'b1);
        p0_rd_req = 1'b0;
        repeat (3) tick();
        chk("to_err_sticky", timeout_err, 1'b1);

        // Reset during BUSY
        p1_rd_addr = 24'h0FEDCB;
        p1_rd_req  = 1'b1;
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        rst = 1'b1;
        #1;
        chk("rst_async_req", mem_req, 1'b0);
        p1_rd_req = 1'b0;
        busy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            busy = busy | {p1_wr_done, p1_rd_done, p0_rd_done};
        end
        chk("rst_no_done", busy, 0);
        chk("rst_err_clr", timeout_err, 1'b0);
        rst = 1'b0;
        tick();
        p0_rd_addr = 24'h0C0FFE;
        p0_rd_req  = 1'b1;
        push(0, 24'h0C0FFE, 16'h0, 16'hA5A5);
        service("post_rst", 1);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single SDRAM controller command port between the LCD refresh reader (port 0, read-only) and the shift-and-draw engine (port 1, read and write). Both requesters use the codebase's level handshake: hold req until a one-cycle done, then drop it. The block sits between those engines and the SDRAM controller. It applies fixed priority with an anti-starvation override, serialises accesses, returns read data, and guards against a hung controller with a timeout.

## Interface
- ADDR_W, 24, SDRAM address width: bank(2) + row(13) + column(9)
- DATA_W, 16, data width
- P0_BURST_MAX, 8, maximum consecutive port-0 grants while port 1 is pending
- TIMEOUT_CYC, 1023, cycles in BUSY before an access is aborted
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- p0_rd_req  in  1  display read request, level
- p0_rd_addr  in  ADDR_W  display read address
- p0_rd_done  out  1  one-cycle read completion
- p0_rd_data  out  DATA_W  read data, valid while p0_rd_done=1
- p1_rd_req, p1_wr_req  in  1  draw-engine read / write requests, level
- p1_rd_addr, p1_wr_addr  in  ADDR_W  draw-engine addresses
- p1_wr_data  in  DATA_W  draw-engine write data
- p1_rd_done, p1_wr_done  out  1  one-cycle completions
- p1_rd_data  out  DATA_W  read data, valid while p1_rd_done=1
- mem_req  out  1  request to SDRAM controller, level
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  write data
- mem_done  in  1  controller completion pulse
- mem_rdata  in  DATA_W  controller read data, valid with mem_done
- timeout_err  out  1  sticky; set on any aborted access

## Operation
- States: IDLE, BUSY, ACK.
- IDLE: evaluate the pending sources P0R, P1R, P1W.
  - Default priority: P0R > P1R > P1W.
  - Override: if burst_cnt == P0_BURST_MAX and any P1 source is pending, grant P1 (read before write).
  - No source pending: stay in IDLE.
  - On grant: latch the grant ID, address, we and wdata into the mem_* registers, set mem_req=1, and go to BUSY.
- burst_cnt:
  - Increments on each P0R grant while a P1 source is pending; saturates at P0_BURST_MAX.
  - Clears on any P1 grant, or when no P1 source is pending.
- BUSY:
  - mem_req and the mem_* payload are held constant.
  - On mem_done: capture mem_rdata, drop mem_req, go to ACK.
  - When wait_cnt reaches TIMEOUT_CYC: drop mem_req, set read data to 16'hDEAD, set timeout_err, go to ACK.
- ACK:
  - Assert exactly one of p0_rd_done / p1_rd_done / p1_wr_done for one cycle, with the data output valid in that cycle.
  - Go to IDLE.
- Requests are sampled only in IDLE. A requester drops req on the edge that ends its done cycle, so no stale re-grant occurs.
- A requester that drops req during BUSY does not abort the access. The access completes, and the done pulse is still issued and ignored upstream.
- A mem_done seen outside BUSY is ignored.
- p1_rd_req and p1_wr_req asserted together: the read is served first and the write stays pending.
- Data outputs hold their last value between done pulses.

## Timing
- Reset (async assert, then first clock after deassert):
  - State IDLE.
  - mem_req, mem_we, all done outputs and timeout_err = 0.
  - mem_addr, mem_wdata, p0_rd_data, p1_rd_data = 0.
  - burst_cnt and wait_cnt = 0.
- Reset asserted mid-access: mem_req drops immediately and no done pulse is issued. The controller is also reset by the same rst.
- Request sampled high in IDLE at cycle t: mem_req=1 from t+1.
- mem_done at cycle t+k: mem_req=0 and requester done=1 at t+k+1, arbiter back in IDLE at t+k+2.
- Minimum spacing is 3 cycles per access (k=1).
- wait_cnt clears on entry to BUSY. Timeout fires when it equals TIMEOUT_CYC, i.e. in the TIMEOUT_CYC+1-th BUSY cycle.
- mem_done arriving in the same cycle the timeout fires is treated as success: no timeout_err, real data returned.

## Structure
- Package sdram_arb_pkg holds:
  - state enum {IDLE, BUSY, ACK};
  - grant ID enum {G_P0R, G_P1R, G_P1W};
  - default ADDR_W/DATA_W;
  - TIMEOUT_DATA = 16'hDEAD.
- One natural sub-module, sdram_arb_pick: a combinational priority picker with the fairness override. Inputs are the three requests and the saturated burst flag; output is the one-hot grant. The top level holds the FSM, counters and registers.

## Test plan
- Single P0 read, mem_done 4 cycles after mem_req, mem_rdata=16'h1234 -> mem_we=0; p0_rd_done pulses one cycle with p0_rd_data=16'h1234; p0_rd_done occurs 6 cycles after p0_rd_req is sampled.
- p1_wr_req with addr 384599, data 16'h0042 -> mem_we=1, mem_addr=384599, mem_wdata=16'h0042; p1_wr_done pulses once.
- P0 held continuously and P1 read pending, P0_BURST_MAX=8 -> exactly 8 P0 grants, then 1 P1 grant, then P0 resumes.
- p1_rd_req and p1_wr_req raised in the same cycle -> the read completes first, then the write; no lost request.
- mem_done never returns, TIMEOUT_CYC=15 -> mem_req drops after 16 BUSY cycles; p0_rd_data=16'hDEAD; timeout_err=1 until rst.
- rst asserted while in BUSY -> mem_req=0 asynchronously; no done pulse; a clean first grant after release.
